cpu_core_param: RTL
===================

// Module: cpu_core_param
// PURPOSE
//  Parametrised multi-cycle CPU core; next generation of the 16-bit cpu. Data/address widths are generic.
//  Memory is external over a req/ack handshake with variable latency. Adds Z/N-conditional branches, HALT and a debug register-read port.
//  Instantiated under a top that supplies RAM and bus.
// PARAMETERS
//  DW        16  data + register width; instruction = mem_rdata[15:0]; DW>=16
//  AW        16  address width; AW<=DW; addresses wrap mod 2^AW
//  RESET_PC  0   PC value after reset
// PORTS
//  CLK          in   1   clock, rising edge
//  reset_n      in   1   asynchronous, active-low reset
//  mem_req      out  1   memory request; held until ack
//  mem_we       out  1   1=write, 0=read; valid with mem_req
//  mem_addr     out  AW  address; stable while mem_req=1
//  mem_wdata    out  DW  store data; stable while mem_req=1
//  mem_rdata    in   DW  read data; valid in the cycle mem_ack=1
//  mem_ack      in   1   transfer completes in the cycle req=1 && ack=1
//  pc           out  AW  current PC
//  retire       out  1   1-cycle pulse: an instruction completed
//  halted       out  1   core in HALT
//  dbg_ra       in   4   debug read register index
//  dbg_rdata    out  DW  R[dbg_ra], combinational, no side effects
// BEHAVIOUR
//  Encoding: op=IR[15:11], rd=IR[10:7], rb=IR[6:3], imm=IR[6:0]. 16 regs R0..R15; all writable.
//  Ops: 0 ADD 1 SUB 2 OR 3 AND 4 XOR 5 SL 6 SR, then 7-13 immediate forms of the same. R-type: R[rd]=R[rd] op R[rb].
//  I-type: R[rd]=R[rd] op zext(imm). Shift amount = operand[$clog2(DW)-1:0]; SR is logical.
//  14 GT, 15 LT, 16 EQ: R[rd] = (R[rd] cmp R[rb]) ? 1 : 0, unsigned.
//  Ops 0-16 set Z=(result==0) and N=result[DW-1]. No other op changes flags.
//  17 BR: PC=PCf+1+sext(imm). 20 BZ: same if Z=1. 21 BN: same if N=1. PCf = fetch address, mod 2^AW.
//  18 STW: MEM[R[rb][AW-1:0]]=R[rd]. 19 LDW: R[rd]=MEM[R[rb][AW-1:0]]. 31 HALT. Any other opcode is a NOP.
//  States: FETCH -> DECODE -> EXEC -> {FETCH | MEM | HALT}; MEM -> FETCH.
//   FETCH: req=1, we=0, addr=PC; on ack: IR<=rdata[15:0], PC<=PC+1.
//   DECODE: latch A=R[rd], B=R[rb].
//   EXEC: ALU writeback + flags, branch PC update, or setup MEM. Non-memory ops pulse retire.
//   MEM: req=1, we=(op==STW); on ack: LDW writes R[rd]<=rdata; retire pulses; go to FETCH.
//   HALT: absorbing; req=0, halted=1, retire pulses once on entry. Left only by reset.
//  Handshake: ack sampled only while req=1; ack with req=0 is ignored.
//   req, addr, we and wdata are held unchanged until the ack cycle.
//   req=0 in the cycle after ack (DECODE or FETCH re-entry from MEM deasserts first: one idle cycle between transfers).
//  Latency with zero-wait memory (ack same cycle as req): ALU/branch/NOP 3 cycles; LDW/STW 4; each wait cycle adds 1.
//  Reset (async, any state, mid-transfer included): state=FETCH, PC=RESET_PC, IR=0, Z=N=0, all R=0.
//   Outputs go to req=0, we=0, retire=0, halted=0 immediately. An in-flight transfer is abandoned; memory must tolerate req dropping.
//  Widths: all arithmetic mod 2^DW; carries discarded. PC+1 and branch targets wrap mod 2^AW.
// TESTING
//  Reset: assert reset_n=0 mid-FETCH with req=1 -> req=0 same cycle.
//   Release -> pc=0, first req addr=0, dbg R1..R15 = 0.
//  ALU chain, zero-wait: ADDI R1,5; ADDI R2,3; SUB R1,R2; SUB R1,R1.
//   -> R1=2 then 0 with Z=1; retire every 3 cycles.
//  Wait states: ack delayed 4 cycles on a fetch -> req/addr stable all 4 cycles, retire delayed by 4.
//   ack asserted with req=0 -> ignored.
//  Memory: R3=0x20, R4=0xBEEF; STW R4,(R3); LDW R5,(R3) -> write at 0x20 with wdata=0xBEEF, R5=0xBEEF.
//   4 cycles each; flags unchanged.
//  Branch: EQ R1,R1 (Z=0); BZ -> not taken. SUB R1,R1 (Z=1); BZ imm=0x7E -> pc = PCf-1.
//   BR at PCf=0 with imm=0x7F -> pc wraps to 0.
//  HALT / illegal: opcode 22 -> NOP, pc+1, R unchanged. HALT -> halted=1, req stays 0 for 20 cycles, single retire.

Source files
------------

// File: rtl/cpu_core_param.sv
// Parametrised multi-cycle CPU core: 16 registers, Z/N flags, variable-latency req/ack
// memory port, conditional branches, HALT and a side-effect-free debug register read.
module cpu_core_param #(
    parameter int              DW       = 16,
    parameter int              AW       = 16,
    parameter logic [AW-1:0]   RESET_PC = {AW{1'b0}}
) (
    input  logic          CLK,
    input  logic          reset_n,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic [AW-1:0] pc,
    output logic          retire,
    output logic          halted,
    input  logic [3:0]    dbg_ra,
    output logic [DW-1:0] dbg_rdata
);
    localparam int SW = $clog2(DW);

    localparam logic [4:0] OP_EQ   = 5'd16;
    localparam logic [4:0] OP_BR   = 5'd17;
    localparam logic [4:0] OP_STW  = 5'd18;
    localparam logic [4:0] OP_LDW  = 5'd19;
    localparam logic [4:0] OP_BZ   = 5'd20;
    localparam logic [4:0] OP_BN   = 5'd21;
    localparam logic [4:0] OP_HALT = 5'd31;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [15:0]   ir_q, ir_d;
    logic [DW-1:0] a_q, a_d, b_q, b_d;
    logic          z_q, z_d, n_q, n_d;
    logic          req_q, req_d, we_q, we_d;
    logic          retire_q, retire_d, halted_q, halted_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rf_q [16];

    logic          rf_we_s;
    logic [DW-1:0] rf_wd_s;
    logic [4:0]    op_s;
    logic [3:0]    rd_s, rb_s;
    logic [6:0]    imm_s;
    logic [DW-1:0] opnd_s, alu_s;
    logic [AW-1:0] target_s;

    assign op_s  = ir_q[15:11];
    assign rd_s  = ir_q[10:7];
    assign rb_s  = ir_q[6:3];
    assign imm_s = ir_q[6:0];

    // pc_q already holds PCf+1 by EXEC, so the branch target is a single add
    assign target_s = pc_q + {{(AW-7){imm_s[6]}}, imm_s};

    // ALU: immediate forms reuse the register-form operation on a zero-extended operand
    always_comb begin
        opnd_s = b_q;
        alu_s  = {DW{1'b0}};
        if ((op_s >= 5'd7) && (op_s <= 5'd13)) begin
            opnd_s = {{(DW-7){1'b0}}, imm_s};
        end else begin
            opnd_s = b_q;
        end
        case (op_s)
            5'd0, 5'd7:  alu_s = a_q + opnd_s;
            5'd1, 5'd8:  alu_s = a_q - opnd_s;
            5'd2, 5'd9:  alu_s = a_q | opnd_s;
            5'd3, 5'd10: alu_s = a_q & opnd_s;
            5'd4, 5'd11: alu_s = a_q ^ opnd_s;
            5'd5, 5'd12: alu_s = a_q << opnd_s[SW-1:0];
            5'd6, 5'd13: alu_s = a_q >> opnd_s[SW-1:0];
            5'd14:       alu_s = {{(DW-1){1'b0}}, (a_q > b_q)};
            5'd15:       alu_s = {{(DW-1){1'b0}}, (a_q < b_q)};
            5'd16:       alu_s = {{(DW-1){1'b0}}, (a_q == b_q)};
            default:     alu_s = {DW{1'b0}};
        endcase
    end

    // Next-state, datapath updates and next values of the registered bus outputs
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        z_d      = z_q;
        n_d      = n_q;
        retire_d = 1'b0;
        rf_we_s  = 1'b0;
        rf_wd_s  = alu_s;
        case (state_q)
            S_FETCH: begin
                if (req_q && mem_ack) begin
                    ir_d    = mem_rdata[15:0];
                    pc_d    = pc_q + {{(AW-1){1'b0}}, 1'b1};
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                a_d     = rf_q[rd_s];
                b_d     = rf_q[rb_s];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                retire_d = 1'b1;
                state_d  = S_FETCH;
                if (op_s <= OP_EQ) begin
                    rf_we_s = 1'b1;
                    z_d     = (alu_s == {DW{1'b0}});
                    n_d     = alu_s[DW-1];
                end else if ((op_s == OP_BR) || ((op_s == OP_BZ) && z_q) ||
                             ((op_s == OP_BN) && n_q)) begin
                    pc_d = target_s;
                end else if ((op_s == OP_STW) || (op_s == OP_LDW)) begin
                    retire_d = 1'b0;
                    state_d  = S_MEM;
                end else if (op_s == OP_HALT) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEM: begin
                if (req_q && mem_ack) begin
                    rf_we_s  = (op_s == OP_LDW);
                    rf_wd_s  = mem_rdata;
                    retire_d = 1'b1;
                    state_d  = S_FETCH;
                end else begin
                    state_d = S_MEM;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Re-entering FETCH from MEM spends one idle cycle with req low
        if (state_d == S_MEM) begin
            req_d  = 1'b1;
            we_d   = (op_s == OP_STW);
            addr_d = b_d[AW-1:0];
        end else if ((state_d == S_FETCH) && (state_q != S_MEM)) begin
            req_d  = 1'b1;
            we_d   = 1'b0;
            addr_d = pc_d;
        end else begin
            req_d  = 1'b0;
            we_d   = 1'b0;
            addr_d = pc_d;
        end
        wdata_d  = a_d;
        halted_d = (state_d == S_HALT);
    end

    // State, datapath, register file and output registers
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            ir_q     <= 16'h0000;
            a_q      <= {DW{1'b0}};
            b_q      <= {DW{1'b0}};
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            retire_q <= 1'b0;
            halted_q <= 1'b0;
            addr_q   <= {AW{1'b0}};
            wdata_q  <= {DW{1'b0}};
            for (int i = 0; i < 16; i++) begin
                rf_q[i] <= {DW{1'b0}};
            end
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            a_q      <= a_d;
            b_q      <= b_d;
            z_q      <= z_d;
            n_q      <= n_d;
            req_q    <= req_d;
            we_q     <= we_d;
            retire_q <= retire_d;
            halted_q <= halted_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            if (rf_we_s) begin
                rf_q[rd_s] <= rf_wd_s;
            end
        end
    end

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign pc        = pc_q;
    assign retire    = retire_q;
    assign halted    = halted_q;
    assign dbg_rdata = rf_q[dbg_ra];

endmodule
